// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle for handshake_rr_arbiter: NUM_SRC valid/ready sources on one side,
// one registered valid/ready destination on the other, plus grant status.
interface handshake_rr_arbiter_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_SRC = 4
);
    localparam int unsigned GW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_ready;
    logic                     dst_valid;
    logic [WIDTH-1:0]         dst_data;
    logic                     dst_ready;
    logic [GW-1:0]            grant_id;
    logic                     busy;

    // Environment side: drives the sources and the destination ready.
    modport master (
        output src_valid, src_data, dst_ready,
        input  src_ready, dst_valid, dst_data, grant_id, busy
    );

    // Arbiter side.
    modport slave (
        input  src_valid, src_data, dst_ready,
        output src_ready, dst_valid, dst_data, grant_id, busy
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Burst round-robin arbiter sharing one registered valid/ready destination among NUM_SRC sources.
// Define HANDSHAKE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module handshake_rr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input logic                   clk,
    input logic                   s_rst_n,
    handshake_rr_arbiter_if.slave bus
);
    localparam int unsigned GW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic               dst_valid_q, dst_valid_d;
    logic [WIDTH-1:0]   dst_data_q, dst_data_d;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
`endif

    logic [NUM_SRC-1:0] src_ready;
    logic [GW-1:0]      winner;
    logic [GW-1:0]      cand;
    logic               found;
    logic               grant_done;

    // Winner selection only matters in IDLE; it never feeds src_ready.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cand = GW'(i);
            if (!found && bus.src_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`else
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = GW'((32'(rr_ptr_q) + i) % NUM_SRC);
            if (!found && bus.src_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        src_ready = '0;
        if (state_q == GRANT) begin
            src_ready[grant_id_q] = !dst_valid_q || bus.dst_ready;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        grant_done  = 1'b0;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        // A load below overrides this drain.
        if (dst_valid_q && bus.dst_ready) begin
            dst_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = winner;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!bus.src_valid[grant_id_q]) begin
                    grant_done = 1'b1;
                end else if (src_ready[grant_id_q]) begin
                    dst_valid_d = 1'b1;
                    dst_data_d  = bus.src_data[grant_id_q*WIDTH +: WIDTH];
                    if (beat_cnt_q == LAST_BEAT) begin
                        grant_done = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_done) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
            rr_ptr_d   = grant_id_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= GW'(NUM_SRC - 1);
`endif
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
`ifndef HANDSHAKE_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.dst_valid = dst_valid_q;
    assign bus.dst_data  = dst_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q == GRANT);
endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: single source, fairness, backpressure,
// early release and mid-burst reset, with expectations written per cycle.
module tb_handshake_rr_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic s_rst_n;
    always #5 clk = ~clk;

    handshake_rr_arbiter_if #(.WIDTH(W), .NUM_SRC(N)) bus ();

    handshake_rr_arbiter #(.WIDTH(W), .NUM_SRC(N), .BURST_LEN(BL)) dut (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cnt [N];
    logic [7:0]  dat [N];
    logic [7:0]  exp_nxt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Each source presents its current word while it still has beats left.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.src_valid[i]         = (cnt[i] != 0);
            bus.src_data[i*W +: W]   = dat[i];
        end
    endtask

    task automatic check_outputs(input string tag, input logic b, input logic [1:0] g,
                                 input logic dv, input logic [7:0] dd, input logic [3:0] sr);
        chk({tag, ".busy"},      32'(bus.busy),      32'(b));
        chk({tag, ".grant_id"},  32'(bus.grant_id),  32'(g));
        chk({tag, ".dst_valid"}, 32'(bus.dst_valid), 32'(dv));
        chk({tag, ".dst_data"},  32'(bus.dst_data),  32'(dd));
        chk({tag, ".src_ready"}, 32'(bus.src_ready), 32'(sr));
    endtask

    // One clock: record handshakes just before the edge, advance sources, then check.
    task automatic cyc(input string tag, input logic b, input logic [1:0] g,
                       input logic dv, input logic [7:0] dd, input logic [3:0] sr);
        logic [N-1:0] hs;
        drive();
        #1;
        hs = bus.src_valid & bus.src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                dat[i]++;
                cnt[i]--;
            end
        end
        drive();
        check_outputs(tag, b, g, dv, dd, sr);
    endtask

    task automatic do_reset(input string tag);
        s_rst_n       = 1'b0;
        bus.dst_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            dat[i] = '0;
        end
        drive();
        #1;
        check_outputs(tag, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        @(posedge clk);
        #3;
        s_rst_n = 1'b1;
    endtask

    initial begin
        int         order [5];
        int         id;
        logic [3:0] sr;
        logic [7:0] last;
        logic [7:0] e;

        s_rst_n       = 1'b1;
        bus.dst_ready = 1'b1;
        bus.src_valid = '0;
        bus.src_data  = '0;
        #2;

        // Single source, six beats: 4-beat burst, one bubble, then 2 beats.
        do_reset("rst0");
        cnt[0] = 6;
        dat[0] = 8'h11;
        cyc("single.e1", 1'b1, 2'd0, 1'b0, 8'h00, 4'b0001);
        cyc("single.e2", 1'b1, 2'd0, 1'b1, 8'h11, 4'b0001);
        cyc("single.e3", 1'b1, 2'd0, 1'b1, 8'h12, 4'b0001);
        cyc("single.e4", 1'b1, 2'd0, 1'b1, 8'h13, 4'b0001);
        cyc("single.e5", 1'b0, 2'd0, 1'b1, 8'h14, 4'b0000);
        cyc("single.e6", 1'b1, 2'd0, 1'b0, 8'h14, 4'b0001);
        cyc("single.e7", 1'b1, 2'd0, 1'b1, 8'h15, 4'b0001);
        cyc("single.e8", 1'b1, 2'd0, 1'b1, 8'h16, 4'b0001);
        cyc("single.e9", 1'b0, 2'd0, 1'b0, 8'h16, 4'b0000);

        // All four sources continuously valid.
        do_reset("rst1");
`ifdef HANDSHAKE_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < N; i++) begin
            cnt[i]     = 100;
            dat[i]     = 8'((i + 1) * 16);
            exp_nxt[i] = 8'((i + 1) * 16);
        end
        last = 8'h00;
        for (int g = 0; g < 5; g++) begin
            id = order[g];
            sr = 4'(1 << id);
            cyc("rr.arb", 1'b1, 2'(id), 1'b0, last, sr);
            for (int k = 0; k < BL; k++) begin
                e = exp_nxt[id];
                exp_nxt[id]++;
                cyc("rr.beat", (k < BL - 1), 2'(id), 1'b1, e, (k < BL - 1) ? sr : 4'b0000);
                last = e;
            end
        end

        // Backpressure for three cycles after the first beat of source 1.
        do_reset("rst2");
        cnt[1] = 4;
        dat[1] = 8'h50;
        cyc("bp.e1", 1'b1, 2'd1, 1'b0, 8'h00, 4'b0010);
        cyc("bp.e2", 1'b1, 2'd1, 1'b1, 8'h50, 4'b0010);
        bus.dst_ready = 1'b0;
        #1;
        chk("bp.stall_ready", 32'(bus.src_ready), 32'(4'b0000));
        cyc("bp.e3", 1'b1, 2'd1, 1'b1, 8'h50, 4'b0000);
        cyc("bp.e4", 1'b1, 2'd1, 1'b1, 8'h50, 4'b0000);
        cyc("bp.e5", 1'b1, 2'd1, 1'b1, 8'h50, 4'b0000);
        bus.dst_ready = 1'b1;
        cyc("bp.e6", 1'b1, 2'd1, 1'b1, 8'h51, 4'b0010);
        cyc("bp.e7", 1'b1, 2'd1, 1'b1, 8'h52, 4'b0010);
        cyc("bp.e8", 1'b0, 2'd1, 1'b1, 8'h53, 4'b0000);
        cyc("bp.e9", 1'b0, 2'd1, 1'b0, 8'h53, 4'b0000);

        // Source 2 drops valid after two beats; source 3 is served next.
        do_reset("rst3");
        cnt[2] = 2;
        dat[2] = 8'h30;
        cnt[3] = 1;
        dat[3] = 8'h40;
        cyc("early.e1", 1'b1, 2'd2, 1'b0, 8'h00, 4'b0100);
        cyc("early.e2", 1'b1, 2'd2, 1'b1, 8'h30, 4'b0100);
        cyc("early.e3", 1'b1, 2'd2, 1'b1, 8'h31, 4'b0100);
        cyc("early.e4", 1'b0, 2'd2, 1'b0, 8'h31, 4'b0000);
        cyc("early.e5", 1'b1, 2'd3, 1'b0, 8'h31, 4'b1000);
        cyc("early.e6", 1'b1, 2'd3, 1'b1, 8'h40, 4'b1000);
        cyc("early.e7", 1'b0, 2'd3, 1'b0, 8'h40, 4'b0000);

        // Asynchronous reset while beat 3 of a source-1 grant is on the output.
        do_reset("rst4");
        cnt[1] = 10;
        dat[1] = 8'h60;
        cyc("mid.e1", 1'b1, 2'd1, 1'b0, 8'h00, 4'b0010);
        cyc("mid.e2", 1'b1, 2'd1, 1'b1, 8'h60, 4'b0010);
        cyc("mid.e3", 1'b1, 2'd1, 1'b1, 8'h61, 4'b0010);
        cyc("mid.e4", 1'b1, 2'd1, 1'b1, 8'h62, 4'b0010);
        #2;
        s_rst_n = 1'b0;
        #1;
        check_outputs("mid.async", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
        #2;
        s_rst_n = 1'b1;
        cnt[0]  = 1;
        dat[0]  = 8'h70;
        cyc("mid.r1", 1'b1, 2'd0, 1'b0, 8'h00, 4'b0001);
        cyc("mid.r2", 1'b1, 2'd0, 1'b1, 8'h70, 4'b0001);
        cyc("mid.r3", 1'b0, 2'd0, 1'b0, 8'h70, 4'b0000);
        cyc("mid.r4", 1'b1, 2'd1, 1'b0, 8'h70, 4'b0010);
        cyc("mid.r5", 1'b1, 2'd1, 1'b1, 8'h63, 4'b0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/handshake_rr_arbiter.md
# handshake_rr_arbiter

Round-robin arbiter that shares one valid/ready destination port (the write buffer that stores a beat on every `vaild && ready` transfer) between NUM_SRC source interfaces. Each grant covers a burst of up to BURST_LEN beats, and the arbiter keeps the winner until the burst ends or the source drops valid. Output data passes through one registered pipeline stage that preserves full throughput. The block sits between the source interfaces and the destination buffer.

## Interface
- WIDTH, 8, data width per beat
- NUM_SRC, 4, number of requesters; must be ≥ 2
- BURST_LEN, 4, maximum beats per grant; must be ≥ 1
- clk  in  1  clock; all logic on its rising edge
- s_rst_n  in  1  reset; asynchronous assert, active-low
- src_valid  in  NUM_SRC  per-source valid; bit i belongs to source i
- src_data  in  NUM_SRC*WIDTH  source i data in bits [i*WIDTH +: WIDTH]
- src_ready  out  NUM_SRC  per-source ready; one-hot or zero
- dst_valid  out  1  registered valid toward the destination
- dst_data  out  WIDTH  registered data toward the destination
- dst_ready  in  1  destination ready
- grant_id  out  $clog2(NUM_SRC)  index of the current or last grantee
- busy  out  1  high while in state GRANT

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If any src_valid bit is high, select a winner, register it in grant_id, and move to GRANT at the next edge.
  - Otherwise stay in IDLE.
- Round-robin selection:
  - The search starts at rr_ptr+1, wraps modulo NUM_SRC, and picks the first source with valid high.
  - rr_ptr takes the grantee index when the grant is released.
- GRANT:
  - src_ready[grant_id] = !dst_valid || dst_ready. All other src_ready bits are 0.
  - A beat transfers when src_valid[grant_id] && src_ready[grant_id]. On a transfer: dst_data <= src data, dst_valid <= 1, beat_cnt <= beat_cnt+1.
  - Release to IDLE when a transfer occurs with beat_cnt == BURST_LEN-1.
  - Release to IDLE when src_valid[grant_id] is low. No transfer happens in that cycle.
  - On release, beat_cnt returns to 0.
- Output stage:
  - If dst_valid && dst_ready and there is no new load, dst_valid <= 0.
  - dst_data holds its value while dst_valid && !dst_ready.
- Beat counter: width $clog2(BURST_LEN+1). It never exceeds BURST_LEN-1.
- Reset values (asynchronous, s_rst_n low):
  - dst_valid=0, dst_data=0, grant_id=0, busy=0, src_ready=0.
  - State is IDLE, beat_cnt=0, rr_ptr=NUM_SRC-1, so source 0 wins first.
- Reset mid-burst: the in-flight dst beat is discarded (dst_valid=0 immediately). Arbitration restarts from source 0.
- Sources must hold valid and data until they see ready. A request with valid deasserted before its grant is simply skipped.

## Timing
- Arbitration latency: 1 cycle. valid rising in IDLE at edge k gives busy=1 and src_ready after edge k+1.
- The first beat appears on dst_valid/dst_data after edge k+2.
- With dst_ready=1, throughput inside a grant is one beat per cycle.
- Each release inserts exactly one IDLE cycle before the next grant, so there is one bubble per burst boundary.
- src_ready is combinational from state and dst_valid/dst_ready. There is no combinational path from src_valid to src_ready.
- dst_valid, dst_data, grant_id and busy are registered, with no combinational input-to-output path.

## Configuration
- Macro `HANDSHAKE_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority. The lowest index with valid high always wins, and rr_ptr is not implemented.
- Undefined (default): round-robin as specified above.
- Burst and timing behaviour is identical in both modes.

## Test plan
- Single source: after reset, src_valid=4'b0001, data 0x11..0x16, dst_ready=1. Expected dst sequence is 0x11–0x14, one idle cycle, then 0x15–0x16. grant_id=0 throughout.
- Round-robin fairness: all four sources valid continuously, BURST_LEN=4. Expected grant order 0,1,2,3,0, with exactly 4 beats per grant and one bubble between grants.
- Backpressure: dst_ready=0 for 3 cycles mid-burst. Expected: dst_data holds, src_ready=0 on every cycle dst_valid && !dst_ready, no beat is lost or duplicated, and the beat count per grant is unchanged.
- Early release: source 2 drops valid after 2 beats. Expected: busy falls at the next edge, the next grant goes to source 3, and source 2 loses its remaining burst slots.
- Mid-burst reset: assert s_rst_n=0 asynchronously during beat 3 of a grant to source 1. Expected: dst_valid=0 with no clock, grant_id=0, and after release source 0 wins first.
- Fixed-priority build (macro defined): sources 0 and 3 continuously valid. Expected: source 0 receives every grant and source 3 never receives src_ready.
